// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a master and the apb_mem_slave word memory.
// Clock and reset stay outside the bundle as plain module ports.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave wrapping a DEPTH-word memory with byte strobes, a fixed number
// of wait states per transfer, out-of-range error response and abort on
// PSEL drop. Bus signals are sampled on the edge entering READY; writes
// land in memory on the edge that leaves READY.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input logic             PCLK,
  input logic             PRESET,
  apb_mem_slave_if.slave  bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Transfer captured on the edge entering READY, committed on the edge leaving it.
  logic                  wr_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;

  logic             setup;
  logic             addr_err;
  logic [IDX_W-1:0] idx;
  logic             enter_ready;
  logic             mem_we;

  // Decode of the live bus: setup phase, range check and the READY entry condition.
  always_comb begin
    setup       = bus.PSEL && !bus.PENABLE;
    addr_err    = {1'b0, bus.PADDR} >= DEPTH_EXT;
    idx         = bus.PADDR[IDX_W-1:0];
    enter_ready = ((state == IDLE) && setup && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && bus.PSEL && bus.PENABLE && (wait_cnt == 4'd0));
    mem_we      = (state == READY) && wr_q && !bus.PSLVERR;
  end

  // Transfer FSM with registered PREADY/PSLVERR/PRDATA and the captured request.
  // NOTE: every register in a clocked block uses <=, so all of them see the
  // pre-edge values of each other regardless of statement order.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      bus.PRDATA  <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else begin
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      if (enter_ready) begin
        bus.PREADY  <= 1'b1;
        bus.PSLVERR <= addr_err;
        wr_q        <= bus.PWRITE;
        idx_q       <= idx;
        wdata_q     <= bus.PWDATA;
        strb_q      <= bus.PSTRB;
        if (!bus.PWRITE) begin
          bus.PRDATA <= addr_err ? '0 : mem[idx];
        end
      end
      case (state)
        IDLE: begin
          if (setup) begin
            if (WAIT_STATES == 0) begin
              state <= READY;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!bus.PSEL) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end else if (bus.PENABLE) begin
            if (wait_cnt == 4'd0) begin
              state <= READY;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
        end
        READY:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory array: byte-masked write on the completing edge of an in-range write.
  // NOTE: the array is cleared by reset because the memory must read back as
  // zero after PRESET; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
- REQ-001: Parameter ADDR_WIDTH, default 8; width of PADDR, a word address.
- REQ-002: Parameter DATA_WIDTH, default 32; data width, legal values 8, 16, 32, 64.
- REQ-003: Parameter DEPTH, default 64; number of memory words, 1..2**ADDR_WIDTH.
- REQ-004: Parameter WAIT_STATES, default 2; PREADY-low access cycles inserted per transfer, 0..15.
- REQ-005: PCLK  input  1  clock, all state on rising edge.
- REQ-006: PRESET  input  1  reset; one clock; reset is asynchronous and active-high.
- REQ-007: PSEL  input  1  slave select.
- REQ-008: PENABLE  input  1  access-phase indicator.
- REQ-009: PWRITE  input  1  1 = write, 0 = read.
- REQ-010: PADDR  input  ADDR_WIDTH  word address.
- REQ-011: PWDATA  input  DATA_WIDTH  write data.
- REQ-012: PSTRB  input  DATA_WIDTH/8  byte write strobes, bit n enables PWDATA[8n+7:8n].
- REQ-013: PRDATA  output  DATA_WIDTH  read data, registered.
- REQ-014: PREADY  output  1  transfer-complete, registered.
- REQ-015: PSLVERR  output  1  error response, registered.

Function
- REQ-016: The FSM SHALL have states IDLE, WAIT, READY.
- REQ-017: IDLE -> WAIT (WAIT_STATES>0) or READY (WAIT_STATES=0) on a setup cycle (PSEL=1, PENABLE=0), loading the wait counter with WAIT_STATES-1.
- REQ-018: WAIT SHALL decrement the counter each cycle while PSEL=1 and PENABLE=1, moving to READY on the edge where the counter equals 0.
- REQ-019: PREADY SHALL be 1 only in READY, so it first goes high WAIT_STATES+1 cycles after the setup cycle.
- REQ-020: READY SHALL last exactly one cycle; the transfer completes on that edge and the FSM returns to IDLE.
- REQ-021: A setup cycle in the cycle after READY SHALL be accepted (back-to-back transfers, no dead cycle required).
- REQ-022: PSEL=0 while in WAIT SHALL abort the transfer to IDLE, with no memory write and PREADY/PSLVERR remaining 0.
- REQ-023: PSEL=1 with PENABLE=1 while in IDLE (no setup cycle) SHALL be ignored.
- REQ-024: A write SHALL update only the bytes with PSTRB=1 at mem[PADDR], on the completing edge only.
- REQ-025: PSTRB=0 on a write SHALL complete normally with memory unchanged and PSLVERR=0.
- REQ-026: A read SHALL load PRDATA with mem[PADDR] on the edge entering READY; PSTRB is ignored.
- REQ-027: PRDATA SHALL hold its value outside READY and SHALL NOT change on writes.
- REQ-028: PADDR >= DEPTH SHALL give PSLVERR=1 in the READY cycle, with no memory write and PRDATA=0 on reads.
- REQ-029: PSLVERR SHALL be 0 whenever PREADY is 0.
- REQ-030: The address, direction, data and strobes SHALL be sampled in the cycle before READY; APB stability across setup/access is the master's responsibility.
- REQ-031: A read of an address written in the immediately preceding transfer SHALL return the new data.

Reset
- REQ-032: PRESET=1 SHALL immediately force IDLE, PREADY=0, PSLVERR=0, PRDATA=0, counter=0 and all memory words to 0.
- REQ-033: Reset asserted mid-transfer SHALL abort it with no memory write.
- REQ-034: The first setup cycle SHALL be accepted on the first rising edge after PRESET deasserts.

Verification
- REQ-035: Defaults: write 0xDEADBEEF to addr 5 with PSTRB=0xF, then read addr 5 -> PREADY high 3 cycles after each setup cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- REQ-036: Write 0x11223344 to addr 7, then write 0xAABBCCDD with PSTRB=0x5, then read addr 7 -> 0x11BB33DD.
- REQ-037: Write to addr 64 (DEPTH=64), then read addr 64 -> PSLVERR=1 with PREADY on both; read data 0; read of addr 0 shows no aliasing (value 0).
- REQ-038: Drop PSEL in the second access cycle of a write to addr 3 -> no PREADY pulse; a later read of addr 3 returns 0.
- REQ-039: WAIT_STATES=0, back-to-back writes to addrs 1, 2, 3 followed by reads -> PREADY high in each access cycle and reads return the written values.
- REQ-040: Assert PRESET in the WAIT cycle of a write to addr 9 after filling addr 9 with 0x55 -> outputs 0 immediately; after release, a read of addr 9 returns 0.
